// File: rtl/mem_sched_pkg.sv
// Shared definitions for the two-bank memory reader scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_sched_pkg;

    // Per-bank lifecycle; encoding is visible on debug taps, keep values fixed.
    typedef enum logic [2:0] {
        BANK_FREE   = 3'd0,
        BANK_LOAD   = 3'd1,
        BANK_ARM    = 3'd2,
        BANK_ACTIVE = 3'd3,
        BANK_DONE   = 3'd4
    } bank_state_t;

    // Cycles of continuous empty in DONE that count as a completion when the
    // engine never pulses read_finished.
    localparam int DONE_HOLD = 4;
    localparam int HOLD_W    = $clog2(DONE_HOLD);

    // Number of completion events raised in one cycle (0..3).
    function automatic logic [1:0] count_events(input logic [2:0] ev);
        return {1'b0, ev[0]} + {1'b0, ev[1]} + {1'b0, ev[2]};
    endfunction

endpackage

// File: rtl/mem_bank_slot.sv
// One bank of the reader: lifecycle FSM, held base/size, stall watchdog.
// Latency: load -> new_data 1 cycle; DONE + read_finished -> FREE 1 cycle.
// Backpressure: none; accepts load only while FREE, the owner gates it.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load, load_base/size     assign a descriptor to this bank (while FREE)
//   empty, count             engine bank-empty flag and words remaining
//   read_finished            engine block-consumed pulse (acts only in DONE)
//   state                    current lifecycle state
//   base, size, new_data     engine-facing bank programming
//   leave_done               combinational: bank completes at this edge
//   stall                    sticky watchdog flag, cleared by the next load
module mem_bank_slot
    import mem_sched_pkg::*;
#(
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_base,
    input  logic [DW-1:0] load_size,
    input  logic          empty,
    input  logic [DW-1:0] count,
    input  logic          read_finished,
    output bank_state_t   state,
    output logic [DW-1:0] base,
    output logic [DW-1:0] size,
    output logic          new_data,
    output logic          leave_done,
    output logic          stall
);

    localparam bit WD_ON = (TIMEOUT > 0);
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    bank_state_t       state_q, state_d;
    logic [HOLD_W-1:0] hold_q;
    logic              hold_expired;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [DW-1:0]     prev_count;
    logic              stall_q;

    assign hold_expired = (state_q == BANK_DONE) && empty &&
                          (hold_q == HOLD_W'(DONE_HOLD - 1));

    always_comb begin
        state_d    = state_q;
        leave_done = 1'b0;
        case (state_q)
            BANK_FREE:   if (load) state_d = BANK_LOAD;
            BANK_LOAD:   state_d = BANK_ARM;
            // Engine pointer resets a cycle after the pulse, so empty may
            // still be high on the first ARM cycle.
            BANK_ARM:    if (!empty) state_d = BANK_ACTIVE;
            BANK_ACTIVE: if (empty) state_d = BANK_DONE;
            BANK_DONE: begin
                if (read_finished || hold_expired) begin
                    state_d    = BANK_FREE;
                    leave_done = 1'b1;
                end
            end
            default:     state_d = BANK_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= BANK_FREE;
        else     state_q <= state_d;
    end

    // Consecutive empty cycles spent in DONE.
    always_ff @(posedge clk) begin
        if (rst || state_q != BANK_DONE || !empty)
            hold_q <= '0;
        else if (hold_q != HOLD_W'(DONE_HOLD - 1))
            hold_q <= hold_q + HOLD_W'(1);
    end

    // Base/size stay put from the load until the bank is reassigned.
    always_ff @(posedge clk) begin
        if (rst) begin
            base <= '0;
            size <= '0;
        end else if (load && state_q == BANK_FREE) begin
            base <= load_base;
            size <= load_size;
        end
    end

    // Watchdog: counts ACTIVE cycles with an unchanged word count.
    always_comb begin
        if (state_q != BANK_ACTIVE || count != prev_count)
            wd_d = '0;
        else if (wd_q == WD_MAX)
            wd_d = wd_q;
        else
            wd_d = wd_q + WD_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q       <= '0;
            prev_count <= '0;
            stall_q    <= 1'b0;
        end else begin
            wd_q       <= wd_d;
            prev_count <= count;
            if (load)
                stall_q <= 1'b0;
            else if (WD_ON && wd_d == WD_MAX)
                stall_q <= 1'b1;
        end
    end

    assign state    = state_q;
    assign new_data = (state_q == BANK_LOAD);
    assign stall    = stall_q;

endmodule

// File: rtl/mem_bank_scheduler.sv
// Host-side scheduler: assigns descriptors ping-pong to two reader banks.
// Latency: accept -> new_data 1 cycle; completion -> count/interrupt 1 cycle.
// Backpressure: o_desc_rdy low while disabled or the next bank is not FREE.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   i_enable / o_engine_enable      accept enable; engine kept on while busy
//   i_desc_stb/base/size, o_desc_rdy  descriptor handshake
//   o_memory_N_base/size/new_data   bank programming towards the engine
//   i_memory_N_empty/count          engine bank status
//   i_read_finished                 engine block-consumed pulse
//   o_busy                          any bank in flight
//   o_done_count                    completed blocks, wraps
//   o_interrupt, i_int_ack          sticky completion interrupt and clear
//   o_stall                         per-bank sticky stall flags
module mem_bank_scheduler
    import mem_sched_pkg::*;
#(
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_desc_stb,
    input  logic [DW-1:0]    i_desc_base,
    input  logic [DW-1:0]    i_desc_size,
    output logic             o_desc_rdy,
    output logic             o_engine_enable,
    output logic [DW-1:0]    o_memory_0_base,
    output logic [DW-1:0]    o_memory_1_base,
    output logic [DW-1:0]    o_memory_0_size,
    output logic [DW-1:0]    o_memory_1_size,
    output logic             o_memory_0_new_data,
    output logic             o_memory_1_new_data,
    input  logic             i_memory_0_empty,
    input  logic             i_memory_1_empty,
    input  logic [DW-1:0]    i_memory_0_count,
    input  logic [DW-1:0]    i_memory_1_count,
    input  logic             i_read_finished,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_done_count,
    output logic             o_interrupt,
    input  logic             i_int_ack,
    output logic [1:0]       o_stall
);

    bank_state_t      st0, st1;
    logic             next_q;
    logic             desc_accept;
    logic             size_zero;
    logic             zero_accept;
    logic [1:0]       load;
    logic [1:0]       leave;
    logic [2:0]       events;
    logic [1:0]       ev_cnt;
    logic [CNT_W-1:0] done_q;
    logic             irq_q;

    // Strict alternation: only the bank the pointer names may take work,
    // even if the other one is idle.
    assign o_desc_rdy  = i_enable && (next_q ? (st1 == BANK_FREE) : (st0 == BANK_FREE));
    assign desc_accept = i_desc_stb && o_desc_rdy;
    assign size_zero   = (i_desc_size == '0);
    // Zero-length blocks complete immediately without touching a bank.
    assign zero_accept = desc_accept && size_zero;
    assign load[0]     = desc_accept && !size_zero && !next_q;
    assign load[1]     = desc_accept && !size_zero &&  next_q;

    assign o_busy          = (st0 != BANK_FREE) || (st1 != BANK_FREE);
    assign o_engine_enable = i_enable || o_busy;

    assign events = {zero_accept, leave[1], leave[0]};
    assign ev_cnt = count_events(events);

    always_ff @(posedge clk) begin
        if (rst) begin
            next_q <= 1'b0;
            done_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (desc_accept && !size_zero)
                next_q <= ~next_q;
            done_q <= done_q + CNT_W'(ev_cnt);
            // A new completion beats a simultaneous acknowledge.
            if (|events)
                irq_q <= 1'b1;
            else if (i_int_ack)
                irq_q <= 1'b0;
        end
    end

    assign o_done_count = done_q;
    assign o_interrupt  = irq_q;

    // read_finished goes to both slots; only a bank sitting in DONE reacts.
    mem_bank_slot #(.DW(DW), .TIMEOUT(TIMEOUT)) u_slot0 (
        .clk           (clk),
        .rst           (rst),
        .load          (load[0]),
        .load_base     (i_desc_base),
        .load_size     (i_desc_size),
        .empty         (i_memory_0_empty),
        .count         (i_memory_0_count),
        .read_finished (i_read_finished),
        .state         (st0),
        .base          (o_memory_0_base),
        .size          (o_memory_0_size),
        .new_data      (o_memory_0_new_data),
        .leave_done    (leave[0]),
        .stall         (o_stall[0])
    );

    mem_bank_slot #(.DW(DW), .TIMEOUT(TIMEOUT)) u_slot1 (
        .clk           (clk),
        .rst           (rst),
        .load          (load[1]),
        .load_base     (i_desc_base),
        .load_size     (i_desc_size),
        .empty         (i_memory_1_empty),
        .count         (i_memory_1_count),
        .read_finished (i_read_finished),
        .state         (st1),
        .base          (o_memory_1_base),
        .size          (o_memory_1_size),
        .new_data      (o_memory_1_new_data),
        .leave_done    (leave[1]),
        .stall         (o_stall[1])
    );

endmodule

// File: tb/tb_mem_bank_scheduler.sv
// Bench for mem_bank_scheduler: random traffic against an occupancy model,
// then directed scenarios for alternation, zero size, stall, disable, reset.
// Runs on its own clock; finishes by itself.
module tb_mem_bank_scheduler;

    localparam int DW = 32;
    localparam int TO = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en, stb, ack, rfin;
    logic [DW-1:0] dbase, dsize;
    logic [DW-1:0] ecnt [2];
    logic          eemp [2];

    logic          rdy, eng_en, nd0, nd1, busy, irq;
    logic [DW-1:0] b0, b1, s0, s1;
    logic [CW-1:0] dcnt;
    logic [1:0]    stall;

    mem_bank_scheduler #(.DW(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_enable            (en),
        .i_desc_stb          (stb),
        .i_desc_base         (dbase),
        .i_desc_size         (dsize),
        .o_desc_rdy          (rdy),
        .o_engine_enable     (eng_en),
        .o_memory_0_base     (b0),
        .o_memory_1_base     (b1),
        .o_memory_0_size     (s0),
        .o_memory_1_size     (s1),
        .o_memory_0_new_data (nd0),
        .o_memory_1_new_data (nd1),
        .i_memory_0_empty    (eemp[0]),
        .i_memory_1_empty    (eemp[1]),
        .i_memory_0_count    (ecnt[0]),
        .i_memory_1_count    (ecnt[1]),
        .i_read_finished     (rfin),
        .o_busy              (busy),
        .o_done_count        (dcnt),
        .o_interrupt         (irq),
        .i_int_ack           (ack),
        .o_stall             (stall)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rdy"},   rdy, 0);
        chk({tag, "_eng"},   eng_en, 0);
        chk({tag, "_nd"},    {nd1, nd0}, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_irq"},   irq, 0);
        chk({tag, "_cnt"},   dcnt, 0);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_base"},  {b1, b0}, 0);
        chk({tag, "_size"},  {s1, s0}, 0);
    endtask

    // ---------------- reference model (bank occupancy view) ----------------
    bit            mfree [2];
    bit            mnext;
    logic [CW-1:0] mcnt;
    bit            mirq;
    logic [DW-1:0] mbase [2];
    logic [DW-1:0] msize [2];
    bit            nd_due [2];
    // ---------------- engine stand-in ----------------
    bit            pend [2];
    bit            eload [2];
    int            svc [$];
    int            rf_bank;
    bit            stim_on;

    task automatic rstep();
        bit exp_rdy, acc, rf_used, ev;
        int rb;
        #1;
        exp_rdy = en && mfree[mnext];
        chk("rdy", rdy, exp_rdy);
        chk("eng_en", eng_en, en || !(mfree[0] && mfree[1]));
        acc     = stb && exp_rdy;
        rf_used = rfin;
        rb      = rf_bank;
        tick();
        ev = 0;
        if (acc) begin
            if (dsize == 0) begin
                mcnt++;
                ev = 1;
            end else begin
                mfree[mnext]  = 0;
                mbase[mnext]  = dbase;
                msize[mnext]  = dsize;
                nd_due[mnext] = 1;
                mnext         = !mnext;
            end
        end
        if (rf_used) begin
            mfree[rb] = 1;
            mcnt++;
            ev = 1;
        end
        if (ev) mirq = 1;
        else if (ack) mirq = 0;

        chk("nd0", nd0, nd_due[0]);
        chk("nd1", nd1, nd_due[1]);
        chk("done_cnt", dcnt, mcnt);
        chk("irq", irq, mirq);
        chk("busy", busy, !(mfree[0] && mfree[1]));
        if (!mfree[0]) begin
            chk("base0", b0, mbase[0]);
            chk("size0", s0, msize[0]);
        end
        if (!mfree[1]) begin
            chk("base1", b1, mbase[1]);
            chk("size1", s1, msize[1]);
        end

        // Engine: drains banks one at a time in load order.
        rfin = 0;
        if (svc.size() > 0) begin
            int h;
            h = svc[0];
            if (eload[h]) begin
                if (eemp[h]) begin
                    rfin    = 1;
                    rf_bank = h;
                    void'(svc.pop_front());
                    eload[h] = 0;
                end else if ($urandom_range(1, 0) == 1) begin
                    ecnt[h] = ecnt[h] - 1;
                    if (ecnt[h] == 0) eemp[h] = 1;
                end
            end
        end
        for (int b = 0; b < 2; b++) begin
            if (pend[b]) begin
                ecnt[b]  = msize[b];
                eemp[b]  = 0;
                eload[b] = 1;
                pend[b]  = 0;
            end
            if (nd_due[b]) begin
                pend[b] = 1;
                svc.push_back(b);
                nd_due[b] = 0;
            end
        end

        if (stim_on) begin
            if ($urandom_range(15, 0) == 0) en = !en;
            stb   = ($urandom_range(1, 0) == 1);
            dbase = $urandom;
            dsize = ($urandom_range(5, 0) == 0) ? 0 : DW'($urandom_range(12, 1));
            ack   = ($urandom_range(7, 0) == 0);
        end else begin
            en  = 0;
            stb = 0;
            ack = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1; en = 0; stb = 0; ack = 0; rfin = 0;
        dbase = 0; dsize = 0;
        for (int b = 0; b < 2; b++) begin
            ecnt[b] = 0;
            eemp[b] = 1;
        end
        tick();
        tick();
        rst = 0;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int ed;
        do_reset();
        chk_idle("reset");

        // ---------------- randomized phase ----------------
        for (int b = 0; b < 2; b++) begin
            mfree[b] = 1; nd_due[b] = 0; pend[b] = 0; eload[b] = 0;
            mbase[b] = 0; msize[b] = 0;
        end
        mnext = 0; mcnt = 0; mirq = 0; rf_bank = 0; stim_on = 1;
        en = 1; stb = 0;
        for (int i = 0; i < 2000; i++) rstep();
        stim_on = 0;
        en = 0; stb = 0; ack = 0;
        for (int i = 0; i < 400 && !(mfree[0] && mfree[1] && svc.size() == 0); i++) rstep();
        chk("drain_busy", busy, 0);

        // ---------------- directed phase ----------------
        do_reset();
        ed = 0;
        en = 1;
        #1 chk("rdy_idle", rdy, 1);
        stb = 1; dbase = 32'h0; dsize = 16;
        tick();
        chk("b2b_nd0", nd0, 1);
        chk("b2b_base0", b0, 32'h0);
        chk("b2b_size0", s0, 16);
        chk("b2b_rdy_mid", rdy, 1);
        dbase = 32'h80000; dsize = 8;
        tick();
        chk("b2b_nd0_once", nd0, 0);
        chk("b2b_nd1", nd1, 1);
        chk("b2b_base1", b1, 32'h80000);
        chk("b2b_size1", s1, 8);
        chk("b2b_rdy_full", rdy, 0);
        chk("b2b_busy", busy, 1);
        stb = 0; dbase = 32'h100; dsize = 4;
        ecnt[0] = 16; eemp[0] = 0; ecnt[1] = 8; eemp[1] = 0;
        tick();
        tick();
        // drain bank1 first so it is free while the pointer names bank0
        for (int i = 7; i >= 1; i--) begin
            ecnt[1] = i;
            tick();
        end
        ecnt[1] = 0; eemp[1] = 1;
        tick();
        stb = 1; rfin = 1;
        tick();
        rfin = 0; ed++;
        chk("fin1_cnt", dcnt, ed);
        chk("fin1_irq", irq, 1);
        chk("strict_rdy", rdy, 0);
        ack = 1;
        tick();
        ack = 0;
        chk("ack_clear", irq, 0);
        chk("strict_rdy2", rdy, 0);
        chk("strict_no_nd", {nd1, nd0}, 0);
        for (int i = 15; i >= 1; i--) begin
            ecnt[0] = i;
            tick();
        end
        ecnt[0] = 0; eemp[0] = 1;
        tick();
        rfin = 1;
        tick();
        rfin = 0; ed++;
        chk("fin0_cnt", dcnt, ed);
        chk("fin0_irq", irq, 1);
        chk("fin0_rdy", rdy, 1);
        tick();
        chk("third_nd0", nd0, 1);
        chk("third_base0", b0, 32'h100);
        chk("third_size0", s0, 4);

        // zero-size descriptor bypasses the bank and keeps the pointer
        dbase = 32'hdead; dsize = 0;
        #1 chk("zero_rdy", rdy, 1);
        tick();
        stb = 0; ed++;
        chk("zero_no_nd", {nd1, nd0}, 0);
        chk("zero_cnt", dcnt, ed);
        chk("zero_irq", irq, 1);
        chk("zero_rdy_after", rdy, 1);
        stb = 1; dbase = 32'h200; dsize = 8;
        tick();
        stb = 0;
        chk("zero_next_nd1", nd1, 1);
        chk("zero_next_base1", b1, 32'h200);

        // stall watchdog on bank1
        tick();
        ecnt[1] = 5; eemp[1] = 0;
        tick();
        repeat (5) tick();
        chk("stall_early", stall, 2'b00);
        repeat (6) tick();
        chk("stall_set", stall, 2'b10);
        ecnt[1] = 0; eemp[1] = 1;
        tick();
        rfin = 1;
        tick();
        rfin = 0; ed++;
        chk("stall_fin_cnt", dcnt, ed);
        chk("stall_sticky", stall, 2'b10);
        ecnt[0] = 4; eemp[0] = 0;
        tick();
        ecnt[0] = 0; eemp[0] = 1;
        tick();
        rfin = 1;
        tick();
        rfin = 0; ed++;
        chk("b0_fin_cnt", dcnt, ed);
        stb = 1; dbase = 32'h400; dsize = 2;
        tick();
        dbase = 32'h500; dsize = 3;
        tick();
        stb = 0;
        chk("reload_nd1", nd1, 1);
        chk("stall_clear", stall, 2'b00);

        // disable with bank1 in flight, bank0 free and next
        tick();
        ecnt[0] = 2; eemp[0] = 0; ecnt[1] = 3; eemp[1] = 0;
        tick();
        ecnt[0] = 0; eemp[0] = 1;
        tick();
        rfin = 1;
        tick();
        rfin = 0; ed++;
        en = 0; stb = 1; dbase = 32'h600; dsize = 5;
        #1;
        chk("dis_rdy", rdy, 0);
        chk("dis_eng_on", eng_en, 1);
        repeat (3) tick();
        chk("dis_no_nd", nd0, 0);
        chk("dis_busy", busy, 1);
        chk("dis_eng_on2", eng_en, 1);
        chk("dis_cnt", dcnt, ed);
        ecnt[1] = 0; eemp[1] = 1;
        tick();
        rfin = 1;
        tick();
        rfin = 0; ed++;
        chk("dis_idle_busy", busy, 0);
        chk("dis_eng_off", eng_en, 0);
        chk("dis_cnt2", dcnt, ed);

        // completion through the empty-hold path (no read_finished)
        en = 1;
        #1 chk("en_rdy", rdy, 1);
        tick();
        stb = 0;
        chk("hold_nd0", nd0, 1);
        chk("hold_base0", b0, 32'h600);
        tick();
        ecnt[0] = 5; eemp[0] = 0;
        tick();
        ecnt[0] = 0; eemp[0] = 1;
        tick();
        repeat (3) tick();
        chk("hold_wait", busy, 1);
        repeat (2) tick();
        ed++;
        chk("hold_free", busy, 0);
        chk("hold_cnt", dcnt, ed);
        chk("hold_irq", irq, 1);

        // reset with bank1 active
        stb = 1; dbase = 32'h700; dsize = 6;
        tick();
        stb = 0;
        chk("mid_nd1", nd1, 1);
        tick();
        ecnt[1] = 6; eemp[1] = 0;
        tick();
        chk("mid_busy", busy, 1);
        rst = 1; en = 0;
        tick();
        chk_idle("rst_mid");
        rst = 0;
        tick();
        chk_idle("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
